rand_range_gen: RTL

//  Parametrised Galois-LFSR random source that returns uniformly distributed values in [0, limit).
//  The LFSR free-runs every clock. Values are requested and returned over valid/ready handshakes.
//  Out-of-range draws are discarded and redrawn (rejection sampling).

---
 rtl/rng_pkg.sv | 18 +
 rtl/lfsr_core.sv | 24 ++
 rtl/rand_range_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// Shared types and default polynomial/seed constants for the random range generator.
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_RESP
  } rng_state_t;

  // Left-shifting Galois masks: polynomial terms below the top degree.
  localparam logic [7:0]  TAPS8  = 8'h71;          // x^8+x^6+x^5+x^4+1
  localparam logic [7:0]  SEED8  = 8'hB9;
  localparam logic [15:0] TAPS16 = 16'h6801;       // x^16+x^14+x^13+x^11+1
  localparam logic [15:0] SEED16 = 16'hACE1;
  localparam logic [31:0] TAPS32 = 32'h0040_0007;  // x^32+x^22+x^2+x+1
  localparam logic [31:0] SEED32 = 32'hDEAD_BEEF;

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR; a zero load value falls back to SEED so the state never locks up.
module lfsr_core #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h71,
  parameter logic [WIDTH-1:0] SEED  = 8'hB9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_val == '0) ? SEED : load_val;
    end else begin
      state <= {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/rand_range_gen.sv
// Rejection-sampling random source: returns uniform values in [0, limit) over valid/ready handshakes.
module rand_range_gen
  import rng_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = TAPS8,
  parameter logic [WIDTH-1:0] SEED      = SEED8,
  parameter int unsigned      OUT_W     = 4,
  parameter int unsigned      MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed_val,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W:0]   req_limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_fallback,
  output logic [WIDTH-1:0] raw
);

  localparam int unsigned     TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  rng_state_t       state, state_next;
  logic [OUT_W:0]   limit;
  logic [TRY_W-1:0] try_cnt;
  logic [OUT_W:0]   cand;
  logic             hit;
  logic             last_try;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_we),
    .load_val (seed_val),
    .state    (raw)
  );

  // Extra MSB lets a limit of 2^OUT_W accept every candidate.
  assign cand     = {1'b0, raw[OUT_W-1:0]};
  assign hit      = cand < limit;
  assign last_try = try_cnt == TRY_LAST;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (req_limit == '0) ? ST_RESP : ST_DRAW;
      end
      ST_DRAW: begin
        if (hit || last_try) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      limit        <= '0;
      try_cnt      <= '0;
      rsp_data     <= '0;
      rsp_fallback <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            limit   <= req_limit;
            try_cnt <= '0;
            if (req_limit == '0) begin
              rsp_data     <= '0;
              rsp_fallback <= 1'b1;
            end
          end
        end
        ST_DRAW: begin
          if (hit) begin
            rsp_data     <= raw[OUT_W-1:0];
            rsp_fallback <= 1'b0;
          end else if (last_try) begin
            rsp_data     <= '0;
            rsp_fallback <= 1'b1;
          end else begin
            try_cnt <= try_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
